nth_bit_select: RTL and testbench

Iterative select unit: given a word and a rank `k`, it returns the bit position of the k-th set bit, counting from the LSB with k starting at 0. It is the inverse of the population-count block: popcount answers "how many ones", this block answers "where is the k-th one". It is used by bit-manipulation datapaths alongside the popcount unit. It scans 4 bits per cycle with a per-nibble popcount and a running remainder, and shares the same valid/idle handshake style.

---
 rtl/nth_bit_select_if.sv | 34 +++
 rtl/nth_bit_select.sv | 126 ++++++++++++
 tb/tb_nth_bit_select.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/nth_bit_select_if.sv
// Request/result bundle for nth_bit_select: operand and rank in, found flag and bit position out.
interface nth_bit_select_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int IW = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] operand;
  logic [IW-1:0]         index;
  logic                  data_valid;
  logic                  result_valid;
  logic                  idle;
  logic                  found;
  logic [IW-1:0]         position;

  modport master (
    output operand,
    output index,
    output data_valid,
    input  result_valid,
    input  idle,
    input  found,
    input  position
  );

  modport slave (
    input  operand,
    input  index,
    input  data_valid,
    output result_valid,
    output idle,
    output found,
    output position
  );
endinterface

// File: rtl/nth_bit_select.sv
// Iterative select: finds the bit position of the k-th set bit, scanning one nibble per cycle.
// Define NTH_BIT_SELECT_EARLY_EXIT_EN to finish right after the hit nibble instead of always scanning the full word.
module nth_bit_select #(
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               clk_en_i,
  nth_bit_select_if.slave    bus
);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam int NIBBLES = DATA_WIDTH / 4;
  localparam int CW = $clog2(NIBBLES);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] data, data_n;
  logic [IW-1:0]         remain, remain_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic                  result_valid, result_valid_n;
  logic                  found, found_n;
  logic [IW-1:0]         position, position_n;

  logic [2:0]            nib_pop;
  logic [1:0]            nib_off;
  logic                  hit;
  logic                  last;

  function automatic logic [2:0] pop4(input logic [3:0] nib);
    return 3'(nib[0]) + 3'(nib[1]) + 3'(nib[2]) + 3'(nib[3]);
  endfunction

  // Position of the rank-th set bit within a nibble; only meaningful when rank < pop4(nib).
  function automatic logic [1:0] nib_offset(input logic [3:0] nib, input logic [1:0] rank);
    logic [2:0] seen;
    logic [1:0] off;
    seen = '0;
    off  = '0;
    for (int i = 0; i < 4; i++) begin
      if (nib[i]) begin
        if (seen == {1'b0, rank}) off = 2'(i);
        seen = seen + 3'd1;
      end
    end
    return off;
  endfunction

  assign nib_pop = pop4(data[3:0]);
  assign nib_off = nib_offset(data[3:0], remain[1:0]);
  assign hit     = remain < IW'(nib_pop);
  assign last    = cnt == CW'(NIBBLES - 1);

  always_comb begin
    state_n        = state;
    data_n         = data;
    remain_n       = remain;
    cnt_n          = cnt;
    result_valid_n = result_valid;
    found_n        = found;
    position_n     = position;
    case (state)
      IDLE: begin
        if (bus.data_valid) begin
          data_n         = bus.operand;
          remain_n       = bus.index;
          cnt_n          = '0;
          result_valid_n = 1'b0;
          found_n        = 1'b0;
          position_n     = '0;
          state_n        = SCAN;
        end
      end
      SCAN: begin
        // Once found, the latched result and remainder are frozen for the rest of the scan.
        if (!found) begin
          if (hit) begin
            found_n    = 1'b1;
            position_n = {cnt, nib_off};
          end else begin
            remain_n = remain - IW'(nib_pop);
          end
        end
        data_n = data >> 4;
        cnt_n  = cnt + CW'(1);
`ifdef NTH_BIT_SELECT_EARLY_EXIT_EN
        if (hit || last) begin
          state_n        = IDLE;
          result_valid_n = 1'b1;
        end
`else
        if (last) begin
          state_n        = IDLE;
          result_valid_n = 1'b1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      result_valid <= 1'b0;
      found        <= 1'b0;
      position     <= '0;
      data         <= '0;
      remain       <= '0;
      cnt          <= '0;
    end else if (clk_en_i) begin
      state        <= state_n;
      result_valid <= result_valid_n;
      found        <= found_n;
      position     <= position_n;
      data         <= data_n;
      remain       <= remain_n;
      cnt          <= cnt_n;
    end
  end

  assign bus.result_valid = result_valid;
  assign bus.idle         = state == IDLE;
  assign bus.found        = found;
  assign bus.position     = position;
endmodule

// File: tb/tb_nth_bit_select.sv
// Bench for nth_bit_select: directed vector table, clock-enable/reset sequences, randomized model check.
module tb_nth_bit_select;
  localparam int DW = 32;
`ifdef NTH_BIT_SELECT_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  localparam int FULL = DW / 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clk_en = 1'b1;

  nth_bit_select_if #(.DATA_WIDTH(DW)) bus ();

  nth_bit_select #(.DATA_WIDTH(DW)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .clk_en_i (clk_en),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] operand;
    logic [4:0]  index;
    logic        found;
    logic [4:0]  position;
    int          latency;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: walk the word from LSB counting ones; latency follows the nibble of the hit.
  task automatic model(input logic [31:0] op, input int idx, output logic f, output logic [4:0] p,
                       output int lat);
    int seen;
    seen = 0;
    f = 1'b0;
    p = '0;
    for (int i = 0; i < DW; i++) begin
      if (op[i]) begin
        if (seen == idx && !f) begin
          f = 1'b1;
          p = 5'(i);
        end
        seen++;
      end
    end
    lat = (EE && f) ? (int'(p) / 4) + 1 : FULL;
  endtask

  // Accepts one operation and waits (bounded) for the result, counting edges after the accept edge.
  task automatic run_check(input string name, input logic [31:0] op, input logic [4:0] idx,
                           input logic ef, input logic [4:0] ep, input int elat);
    int lat;
    @(negedge clk);
    bus.operand    = op;
    bus.index      = idx;
    bus.data_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.data_valid = 1'b0;
    check({name, " valid drop at accept"}, 32'(bus.result_valid), 32'd0);
    check({name, " busy after accept"}, 32'(bus.idle), 32'd0);
    lat = 0;
    while (1) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.result_valid) break;
      if (lat > 100) break;
    end
    check({name, " latency"}, 32'(lat), 32'(elat));
    check({name, " found"}, 32'(bus.found), 32'(ef));
    check({name, " position"}, 32'(bus.position), 32'(ep));
  endtask

  vec_t vecs[$];

  initial begin
    logic       mf;
    logic [4:0] mp;
    int         ml;
    int         cyc;
    logic [31:0] rop;
    int         ridx;

    bus.operand    = '0;
    bus.index      = '0;
    bus.data_valid = 1'b0;

    #2 rst_n = 1'b0;
    #3;
    check("reset idle", 32'(bus.idle), 32'd1);
    check("reset valid", 32'(bus.result_valid), 32'd0);
    check("reset found", 32'(bus.found), 32'd0);
    check("reset position", 32'(bus.position), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs.push_back('{32'h0000_0001, 5'd0,  1'b1, 5'd0,  EE ? 1 : FULL});
    vecs.push_back('{32'h8000_0000, 5'd0,  1'b1, 5'd31, FULL});
    vecs.push_back('{32'hA5A5_A5A5, 5'd9,  1'b1, 5'd18, EE ? 5 : FULL});
    vecs.push_back('{32'h0000_00F0, 5'd4,  1'b0, 5'd0,  FULL});
    vecs.push_back('{32'h0000_0000, 5'd0,  1'b0, 5'd0,  FULL});
    vecs.push_back('{32'hFFFF_FFFF, 5'd31, 1'b1, 5'd31, FULL});
    vecs.push_back('{32'h0001_0000, 5'd0,  1'b1, 5'd16, EE ? 5 : FULL});
    vecs.push_back('{32'h0000_0F00, 5'd2,  1'b1, 5'd10, EE ? 3 : FULL});
    vecs.push_back('{32'h1000_0008, 5'd1,  1'b1, 5'd28, FULL});
    vecs.push_back('{32'h0000_0008, 5'd0,  1'b1, 5'd3,  EE ? 1 : FULL});

    foreach (vecs[i])
      run_check($sformatf("vec%0d", i), vecs[i].operand, vecs[i].index,
                vecs[i].found, vecs[i].position, vecs[i].latency);

    // Results hold in IDLE while nothing is accepted.
    repeat (3) @(posedge clk);
    #1;
    check("hold valid", 32'(bus.result_valid), 32'd1);
    check("hold position", 32'(bus.position), 32'd3);

    // Clock-enable stall plus an ignored request during SCAN.
    @(negedge clk);
    bus.operand    = 32'hFFFF_FFFF;
    bus.index      = 5'd17;
    bus.data_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.operand    = 32'h0000_0001;
    bus.index      = 5'd0;
    cyc = 0;
    @(posedge clk); #1; cyc++;
    bus.data_valid = 1'b0;
    clk_en = 1'b0;
    repeat (3) begin
      @(posedge clk); #1; cyc++;
    end
    check("stall busy", 32'(bus.idle), 32'd0);
    check("stall no valid", 32'(bus.result_valid), 32'd0);
    clk_en = 1'b1;
    while (!bus.result_valid && cyc < 100) begin
      @(posedge clk); #1; cyc++;
    end
    check("stall latency", 32'(cyc), 32'((EE ? 5 : FULL) + 3));
    check("stall found", 32'(bus.found), 32'd1);
    check("stall position", 32'(bus.position), 32'd17);

    // Asynchronous reset during the third SCAN cycle.
    @(negedge clk);
    bus.operand    = 32'hA5A5_A5A5;
    bus.index      = 5'd9;
    bus.data_valid = 1'b1;
    @(posedge clk); #1;
    bus.data_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("arst idle", 32'(bus.idle), 32'd1);
    check("arst valid", 32'(bus.result_valid), 32'd0);
    check("arst found", 32'(bus.found), 32'd0);
    check("arst position", 32'(bus.position), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("post-reset idle", 32'(bus.idle), 32'd1);
    check("post-reset valid", 32'(bus.result_valid), 32'd0);
    run_check("post-reset op", 32'hA5A5_A5A5, 5'd9, 1'b1, 5'd18, EE ? 5 : FULL);

    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 2))
        0: rop = $urandom;
        1: rop = $urandom & $urandom & $urandom;
        default: rop = 32'(1) << $urandom_range(0, 31);
      endcase
      ridx = $urandom_range(0, $countones(rop) + 2);
      if (ridx > 31) ridx = 31;
      model(rop, ridx, mf, mp, ml);
      run_check($sformatf("rand%0d", n), rop, 5'(ridx), mf, mp, ml);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
